// File: rtl/obj_scan_if.sv
// Object scanner bus: DMA capture strobe/data, line timing, and the list head
// presented to the sprite line-buffer renderer with its valid/ready handshake.
interface obj_scan_if;
  logic        DMCS;
  logic [28:0] DO;
  logic        VB;
  logic        HB;
  logic [7:0]  V;
  logic        OBJ_VALID;
  logic        OBJ_READY;
  logic [7:0]  OBJX;
  logic [6:0]  OBJCODE;
  logic [3:0]  OBJROW;
  logic [2:0]  OBJPAL;
  logic        OBJFX;
  logic        LINE_OVF;
  logic        SCAN_BUSY;

  // Environment side: sprite DMA, video timing and the renderer.
  modport master (
    output DMCS, DO, VB, HB, V, OBJ_READY,
    input  OBJ_VALID, OBJX, OBJCODE, OBJROW, OBJPAL, OBJFX, LINE_OVF, SCAN_BUSY
  );

  // Scanner side.
  modport slave (
    input  DMCS, DO, VB, HB, V, OBJ_READY,
    output OBJ_VALID, OBJX, OBJCODE, OBJROW, OBJPAL, OBJFX, LINE_OVF, SCAN_BUSY
  );
endinterface

// File: rtl/obj_scan.sv
// Sprite object scanner. Captures object words streamed by the sprite DMA into
// an object RAM, then during each HBLANK compares every entry against the next
// line and queues the hits in a small FIFO for the line-buffer renderer.
module obj_scan #(
  parameter int NOBJ    = 64,
  parameter int OBJH    = 16,
  parameter int MAXLINE = 8
) (
  input  logic       DOTCK,
  input  logic       RESET,
  obj_scan_if.slave  bus
);

  localparam int IDXW = $clog2(NOBJ);
  localparam int PTRW = $clog2(MAXLINE);
  localparam int CNTW = PTRW + 1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NOBJ - 1);
  localparam logic [7:0]      OBJH_V   = 8'(OBJH);
  localparam logic [3:0]      ROW_MAX  = 4'(OBJH - 1);
  localparam logic [CNTW-1:0] LIST_MAX = CNTW'(MAXLINE);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  // One list entry as presented to the renderer.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] code;
    logic [3:0] row;
    logic [2:0] pal;
    logic       fx;
  } entry_t;

  // Object word field positions.
  localparam int F_FLIPX  = 26;
  localparam int F_FLIPY  = 27;
  localparam int F_ENABLE = 28;

  // Timing edge detection
  logic vb_q, hb_q;
  logic vb_rise, hb_rise, hb_fall;

  // Capture side
  logic [28:0]     ram [NOBJ];
  logic [IDXW-1:0] wptr;
  logic [IDXW-1:0] wr_addr;

  // Scan side
  state_t          state, state_nx;
  logic            scan_start;
  logic            issue;
  logic [7:0]      tgt;
  logic [IDXW-1:0] idx;
  logic            issued_all;
  logic [28:0]     rd_data;
  logic            cmp_valid;
  logic            cmp_last;

  // Compare stage
  logic [7:0]      diff;
  logic [3:0]      row_raw;
  logic [3:0]      row;
  logic            hit;
  logic            push_req;
  logic            push;
  logic            ovf_set;
  entry_t          push_entry;

  // List FIFO
  entry_t          fifo_mem [MAXLINE];
  logic [PTRW-1:0] rd_ptr, wr_ptr;
  logic [CNTW-1:0] count, count_nx;
  logic            pop;
  logic            line_ovf;
  entry_t          head;
  logic            list_valid;

  assign vb_rise = bus.VB & ~vb_q;
  assign hb_rise = bus.HB & ~hb_q;
  assign hb_fall = ~bus.HB & hb_q;

  // Remember last-cycle VB/HB so blanking edges can be seen.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge DOTCK or posedge RESET) begin
    if (RESET) begin
      vb_q <= 1'b0;
      hb_q <= 1'b0;
    end else begin
      vb_q <= bus.VB;
      hb_q <= bus.HB;
    end
  end

  // A write on the same cycle VB rises belongs to the new frame, so it goes to entry 0.
  assign wr_addr = vb_rise ? '0 : wptr;

  // DMA write pointer: restarts each frame, wraps modulo the RAM size.
  always_ff @(posedge DOTCK or posedge RESET) begin
    if (RESET) begin
      wptr <= '0;
    end else if (bus.DMCS) begin
      wptr <= wr_addr + 1'b1;
    end else if (vb_rise) begin
      wptr <= '0;
    end
  end

  // Object RAM write port; the DMA always wins over the scanner.
  // NOTE: the RAM has no reset -- it maps onto block RAM, and scan only trusts entries the DMA wrote.
  always_ff @(posedge DOTCK) begin
    if (bus.DMCS) begin
      ram[wr_addr] <= bus.DO;
    end
  end

  // Object RAM read port, one cycle latency; only loaded on issue cycles.
  always_ff @(posedge DOTCK) begin
    if (issue) begin
      rd_data <= ram[idx];
    end
  end

  // FSM state register.
  always_ff @(posedge DOTCK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state, scan start and read issue.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nx   = state;
    scan_start = 1'b0;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (hb_rise && !bus.VB) begin
          state_nx   = S_SCAN;
          scan_start = 1'b1;
        end
      end
      S_SCAN: begin
        // A DMA write occupies the RAM port, so the scan holds its index.
        issue = !bus.DMCS && !issued_all;
        if (bus.VB || hb_fall || (cmp_valid && cmp_last)) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Scan index and compare-stage bookkeeping, one cycle behind the read.
  always_ff @(posedge DOTCK or posedge RESET) begin
    if (RESET) begin
      tgt        <= 8'd0;
      idx        <= '0;
      issued_all <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_last   <= 1'b0;
    end else if (scan_start) begin
      tgt        <= bus.V + 8'd1;
      idx        <= '0;
      issued_all <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_last   <= 1'b0;
    end else begin
      cmp_valid <= issue;
      if (issue) begin
        cmp_last <= (idx == LAST_IDX);
        idx      <= idx + 1'b1;
        if (idx == LAST_IDX) begin
          issued_all <= 1'b1;
        end
      end
    end
  end

  // Line compare: vertical distance below the sprite top, wrapping at 256.
  always_comb begin
    diff    = tgt - rd_data[7:0];
    row_raw = diff[3:0] & ROW_MAX;
    row     = rd_data[F_FLIPY] ? (ROW_MAX - row_raw) : row_raw;
    hit     = cmp_valid && rd_data[F_ENABLE] && (diff < OBJH_V);

    push_req = (state == S_SCAN) && hit;
    push     = push_req && (count < LIST_MAX);
    ovf_set  = push_req && (count == LIST_MAX);

    push_entry.x    = rd_data[15:8];
    push_entry.code = rd_data[22:16];
    push_entry.row  = row;
    push_entry.pal  = rd_data[25:23];
    push_entry.fx   = rd_data[F_FLIPX];
  end

  assign list_valid = (count != '0);
  assign pop        = list_valid && bus.OBJ_READY;

  // List occupancy after this cycle's push/pop.
  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  // List FIFO storage; stale slots are never visible because the head is gated by valid.
  always_ff @(posedge DOTCK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // List pointers, occupancy and overflow flag; a scan start discards the old line.
  always_ff @(posedge DOTCK or posedge RESET) begin
    if (RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      line_ovf <= 1'b0;
    end else if (scan_start) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      line_ovf <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nx;
      if (ovf_set) begin
        line_ovf <= 1'b1;
      end
    end
  end

  // Head comes straight from registered storage and pointer, zeroed when empty.
  assign head = list_valid ? fifo_mem[rd_ptr] : '0;

  assign bus.OBJ_VALID = list_valid;
  assign bus.OBJX      = head.x;
  assign bus.OBJCODE   = head.code;
  assign bus.OBJROW    = head.row;
  assign bus.OBJPAL    = head.pal;
  assign bus.OBJFX     = head.fx;
  assign bus.LINE_OVF  = line_ovf;
  assign bus.SCAN_BUSY = (state == S_SCAN);

endmodule

// File: tb/tb_obj_scan.sv
// Scoreboard bench for obj_scan: a behavioural object RAM model predicts the
// line list at each scan start; the renderer side pops and compares in order.
module tb_obj_scan;

  logic DOTCK;
  logic RESET;

  obj_scan_if bus ();

  obj_scan #(.NOBJ(64), .OBJH(16), .MAXLINE(8)) dut (
    .DOTCK (DOTCK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial DOTCK = 1'b0;
  always #5 DOTCK = ~DOTCK;

  int tests  = 0;
  int failed = 0;

  logic [28:0] mram [64];
  int          mwptr = 0;
  logic [28:0] img  [64];
  logic [22:0] exp_q [$];
  logic        exp_ovf;

  function automatic logic [28:0] mk_word(input logic [7:0] y, input logic [7:0] x,
                                          input logic [6:0] code, input logic [2:0] pal,
                                          input logic fx, input logic fy, input logic en);
    return {en, fy, fx, pal, code, x, y};
  endfunction

  task automatic step();
    @(posedge DOTCK);
    #1;
  endtask

  // Reference behaviour: walk entries 0..limit-1 against target line t.
  task automatic model_scan(input logic [7:0] t, input int limit);
    int cnt;
    logic [7:0] d;
    logic [3:0] r;
    logic [28:0] w;
    cnt = 0;
    exp_ovf = 1'b0;
    exp_q.delete();
    for (int k = 0; k < limit; k++) begin
      w = mram[k];
      d = t - w[7:0];
      if (w[28] && d < 8'd16) begin
        r = w[27] ? 4'd15 - d[3:0] : d[3:0];
        if (cnt < 8) begin
          exp_q.push_back({w[15:8], w[22:16], r, w[25:23], w[26]});
          cnt++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_img();
    for (int k = 0; k < 64; k++) img[k] = mk_word(8'd200, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // New frame (VB rise) followed by a full 64-word DMA burst of img.
  task automatic load_img();
    bus.VB = 1'b1;
    step();
    bus.VB = 1'b0;
    step();
    mwptr = 0;
    for (int k = 0; k < 64; k++) begin
      bus.DMCS = 1'b1;
      bus.DO   = img[k];
      step();
      mram[mwptr] = img[k];
      mwptr = (mwptr + 1) % 64;
    end
    bus.DMCS = 1'b0;
    step();
  endtask

  // HB rise on line v; optional DMCS stall pulses and HB-fall abort at given busy cycles.
  task automatic run_scan(input logic [7:0] v, input int stall_a, input int stall_b,
                          input int abort_at, output int busy);
    int c;
    model_scan(v + 8'd1, (abort_at < 0) ? 64 : abort_at);
    bus.V  = v;
    bus.HB = 1'b1;
    step();
    c = 0;
    while (bus.SCAN_BUSY && c < 300) begin
      bus.DMCS = (c == stall_a) || (c == stall_b);
      if (bus.DMCS) begin
        bus.DO = mram[mwptr];
        mwptr  = (mwptr + 1) % 64;
      end
      if (c == abort_at) bus.HB = 1'b0;
      step();
      c++;
    end
    bus.DMCS = 1'b0;
    bus.HB   = 1'b0;
    tests++;
    if (c >= 300) begin
      failed++;
      $display("FAIL scan_timeout: SCAN_BUSY still high after %0d cycles, required drop", c);
    end
    busy = c;
    step();
  endtask

  // Scoreboard drain: renderer ready, compare every popped head in order.
  task automatic sb_drain(input string name, output int pops);
    logic [22:0] got;
    logic [22:0] want;
    pops = 0;
    bus.OBJ_READY = 1'b1;
    while (bus.OBJ_VALID && pops < 16) begin
      got = {bus.OBJX, bus.OBJCODE, bus.OBJROW, bus.OBJPAL, bus.OBJFX};
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL %s_extra_pop: got head %h, required no entry", name, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failed++;
          $display("FAIL %s_pop%0d: got head %h, required %h", name, pops, got, want);
        end
      end
      pops++;
      step();
    end
    bus.OBJ_READY = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_missing: got %0d pops, required %0d more", name, pops, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #1;
    tests++;
    if ({bus.OBJ_VALID, bus.OBJX, bus.OBJCODE, bus.OBJROW, bus.OBJPAL, bus.OBJFX,
         bus.LINE_OVF, bus.SCAN_BUSY} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got valid=%b x=%h ovf=%b busy=%b, required all 0",
               bus.OBJ_VALID, bus.OBJX, bus.LINE_OVF, bus.SCAN_BUSY);
    end
    step();
    RESET = 1'b0;
    step();
  endtask

  task automatic test_ram_load();
    int busy, pops;
    for (int k = 0; k < 64; k++)
      img[k] = mk_word(8'(k * 4), 8'(k), 7'(k), 3'(k), 1'(k), 1'b0, 1'b1);
    load_img();
    run_scan(8'd39, -1, -1, -1, busy);
    tests++;
    if (busy !== 65) begin
      failed++;
      $display("FAIL load_busy_len: got %0d cycles, required 65", busy);
    end
    tests++;
    if (bus.LINE_OVF !== 1'b0) begin
      failed++;
      $display("FAIL load_ovf: got %b, required 0", bus.LINE_OVF);
    end
    tests++;
    if (bus.OBJROW !== 4'd12) begin
      failed++;
      $display("FAIL load_first_row: got %0d, required 12", bus.OBJROW);
    end
    sb_drain("load", pops);
    tests++;
    if (pops !== 4) begin
      failed++;
      $display("FAIL load_pop_count: got %0d, required 4", pops);
    end
  endtask

  task automatic test_overflow();
    int busy, pops;
    clear_img();
    for (int k = 0; k < 12; k++) img[k] = mk_word(8'd100, 8'(16 + k), 7'(k), 3'd2, 1'b1, 1'b0, 1'b1);
    img[12] = mk_word(8'd100, 8'd99, 7'd99, 3'd1, 1'b0, 1'b0, 1'b0);
    load_img();
    run_scan(8'd99, -1, -1, -1, busy);
    tests++;
    if (bus.LINE_OVF !== 1'b1) begin
      failed++;
      $display("FAIL ovf_set: got %b, required 1", bus.LINE_OVF);
    end
    sb_drain("ovf", pops);
    tests++;
    if (pops !== 8) begin
      failed++;
      $display("FAIL ovf_pop_count: got %0d, required 8", pops);
    end
    run_scan(8'd149, -1, -1, -1, busy);
    tests++;
    if (bus.LINE_OVF !== 1'b0 || bus.OBJ_VALID !== 1'b0) begin
      failed++;
      $display("FAIL ovf_clear: got ovf=%b valid=%b, required 0 0", bus.LINE_OVF, bus.OBJ_VALID);
    end
  endtask

  task automatic test_wrap();
    int busy, pops;
    clear_img();
    img[0] = mk_word(8'd250, 8'd77, 7'd5, 3'd3, 1'b0, 1'b0, 1'b1);
    load_img();
    run_scan(8'd3, -1, -1, -1, busy);
    tests++;
    if (bus.OBJROW !== 4'd10) begin
      failed++;
      $display("FAIL wrap_row: got %0d, required 10", bus.OBJROW);
    end
    sb_drain("wrap", pops);
    img[0] = mk_word(8'd250, 8'd77, 7'd5, 3'd3, 1'b0, 1'b1, 1'b1);
    load_img();
    run_scan(8'd3, -1, -1, -1, busy);
    tests++;
    if (bus.OBJROW !== 4'd5) begin
      failed++;
      $display("FAIL wrap_flipy_row: got %0d, required 5", bus.OBJROW);
    end
    sb_drain("wrap_fy", pops);
  endtask

  task automatic test_handshake();
    int busy, pops;
    logic [22:0] got;
    logic [22:0] want;
    clear_img();
    img[2] = mk_word(8'd60, 8'd10, 7'd1, 3'd1, 1'b0, 1'b0, 1'b1);
    img[5] = mk_word(8'd55, 8'd20, 7'd2, 3'd2, 1'b1, 1'b0, 1'b1);
    img[9] = mk_word(8'd50, 8'd30, 7'd3, 3'd3, 1'b0, 1'b1, 1'b1);
    load_img();
    run_scan(8'd59, -1, -1, -1, busy);
    for (int i = 0; i < 3; i++) begin
      got = {bus.OBJX, bus.OBJCODE, bus.OBJROW, bus.OBJPAL, bus.OBJFX};
      tests++;
      if (bus.OBJ_VALID !== 1'b1 || got !== exp_q[0]) begin
        failed++;
        $display("FAIL hs_hold%0d: got valid=%b head=%h, required 1 %h", i, bus.OBJ_VALID, got, exp_q[0]);
      end
      step();
    end
    sb_drain("hs", pops);
    tests++;
    if (pops !== 3) begin
      failed++;
      $display("FAIL hs_pop_cycles: got %0d, required 3", pops);
    end
    // Leave two entries behind, then rescan the same line.
    run_scan(8'd59, -1, -1, -1, busy);
    bus.OBJ_READY = 1'b1;
    got  = {bus.OBJX, bus.OBJCODE, bus.OBJROW, bus.OBJPAL, bus.OBJFX};
    want = exp_q.pop_front();
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL hs_single_pop: got %h, required %h", got, want);
    end
    step();
    bus.OBJ_READY = 1'b0;
    run_scan(8'd59, -1, -1, -1, busy);
    sb_drain("hs_rescan", pops);
    tests++;
    if (pops !== 3) begin
      failed++;
      $display("FAIL hs_list_cleared: got %0d pops, required 3", pops);
    end
  endtask

  task automatic test_stall_abort();
    int busy, pops;
    clear_img();
    img[3]  = mk_word(8'd80, 8'd3,  7'd3,  3'd0, 1'b0, 1'b0, 1'b1);
    img[15] = mk_word(8'd78, 8'd15, 7'd15, 3'd1, 1'b1, 1'b0, 1'b1);
    img[30] = mk_word(8'd75, 8'd30, 7'd30, 3'd2, 1'b0, 1'b1, 1'b1);
    img[50] = mk_word(8'd70, 8'd50, 7'd50, 3'd3, 1'b1, 1'b1, 1'b1);
    load_img();
    run_scan(8'd79, 10, 40, -1, busy);
    tests++;
    if (busy !== 67) begin
      failed++;
      $display("FAIL stall_busy_len: got %0d cycles, required 67", busy);
    end
    sb_drain("stall", pops);
    run_scan(8'd79, -1, -1, 20, busy);
    tests++;
    if (busy !== 21) begin
      failed++;
      $display("FAIL abort_busy_len: got %0d cycles, required 21", busy);
    end
    sb_drain("abort", pops);
    tests++;
    if (pops !== 2) begin
      failed++;
      $display("FAIL abort_pop_count: got %0d, required 2", pops);
    end
  endtask

  task automatic test_reset_midscan();
    int busy, pops;
    clear_img();
    img[0] = mk_word(8'd80,  8'd1, 7'd1, 3'd1, 1'b0, 1'b0, 1'b1);
    img[1] = mk_word(8'd79,  8'd2, 7'd2, 3'd2, 1'b0, 1'b0, 1'b1);
    img[2] = mk_word(8'd100, 8'd7, 7'd7, 3'd7, 1'b1, 1'b0, 1'b1);
    img[3] = mk_word(8'd78,  8'd3, 7'd3, 3'd3, 1'b0, 1'b0, 1'b1);
    img[4] = mk_word(8'd77,  8'd4, 7'd4, 3'd4, 1'b0, 1'b0, 1'b1);
    load_img();
    bus.V  = 8'd79;
    bus.HB = 1'b1;
    step();
    // Two DMA writes mid-scan advance the write pointer to 2.
    for (int c = 0; c < 10; c++) begin
      bus.DMCS = (c == 1) || (c == 2);
      if (bus.DMCS) begin
        bus.DO = mram[mwptr];
        mwptr  = (mwptr + 1) % 64;
      end
      step();
    end
    bus.DMCS = 1'b0;
    tests++;
    if (bus.OBJ_VALID !== 1'b1 || bus.SCAN_BUSY !== 1'b1) begin
      failed++;
      $display("FAIL rst_pre: got valid=%b busy=%b, required 1 1", bus.OBJ_VALID, bus.SCAN_BUSY);
    end
    RESET = 1'b1;
    #1;
    tests++;
    if (bus.OBJ_VALID !== 1'b0 || bus.SCAN_BUSY !== 1'b0 || bus.LINE_OVF !== 1'b0) begin
      failed++;
      $display("FAIL rst_async: got valid=%b busy=%b ovf=%b, required 0 0 0",
               bus.OBJ_VALID, bus.SCAN_BUSY, bus.LINE_OVF);
    end
    exp_q.delete();
    mwptr = 0;
    step();
    bus.HB = 1'b0;
    RESET  = 1'b0;
    step();
    bus.DMCS = 1'b1;
    bus.DO   = mk_word(8'd100, 8'hAB, 7'd66, 3'd5, 1'b1, 1'b0, 1'b1);
    step();
    mram[mwptr] = bus.DO;
    mwptr = (mwptr + 1) % 64;
    bus.DMCS = 1'b0;
    step();
    run_scan(8'd99, -1, -1, -1, busy);
    sb_drain("rst_wptr", pops);
    tests++;
    if (pops !== 2) begin
      failed++;
      $display("FAIL rst_wptr_count: got %0d pops, required 2", pops);
    end
  endtask

  initial begin
    RESET         = 1'b1;
    bus.DMCS      = 1'b0;
    bus.DO        = '0;
    bus.VB        = 1'b0;
    bus.HB        = 1'b0;
    bus.V         = 8'd0;
    bus.OBJ_READY = 1'b0;
    test_reset();
    test_ram_load();
    test_overflow();
    test_wrap();
    test_handshake();
    test_stall_abort();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
